// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux
// Display-side consumer of the stopwatch digit bus (m10, m1, s10, s1).
// Time-multiplexes four BCD digits onto a 4-anode, active-low 7-segment
// display. While adj is high, the field chosen by sel blinks. Digits are
// captured once per frame into a shadow register, so the display never tears.
//
// Optional build macro:
//   LEAD_BLANK_EN - when defined, a zero minutes-tens digit is blanked.
//
// Slot order: idx 0 = s1 (an[0]), 1 = s10, 2 = m1 (dp lit), 3 = m10.
// -----------------------------------------------------------------------------
module seg_display_mux #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 2
) (
    input  logic       clkAdj,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic [2:0] m10,
    input  logic [3:0] m1,
    input  logic [2:0] s10,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ZERO  = {SCAN_W{1'b0}};
    localparam logic [BLINK_W-1:0] BLINK_ZERO = {BLINK_W{1'b0}};

    localparam logic [1:0] IDX_S1  = 2'd0;
    localparam logic [1:0] IDX_S10 = 2'd1;
    localparam logic [1:0] IDX_M1  = 2'd2;
    localparam logic [1:0] IDX_M10 = 2'd3;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // BCD to active-low segments, bit order {g,f,e,d,c,b,a}; 10-15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // Active-low one-hot anode for a slot index.
    function automatic logic [3:0] anode_for(input logic [1:0] slot);
        logic [3:0] sel_an;
        case (slot)
            IDX_S1:  sel_an = 4'b1110;
            IDX_S10: sel_an = 4'b1101;
            IDX_M1:  sel_an = 4'b1011;
            IDX_M10: sel_an = 4'b0111;
            default: sel_an = AN_OFF;
        endcase
        return sel_an;
    endfunction

    // State
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_ph_r;
    logic               first_r;
    logic [2:0]         shd_m10_r;
    logic [3:0]         shd_m1_r;
    logic [2:0]         shd_s10_r;
    logic [3:0]         shd_s1_r;
    logic [6:0]         seg_r;
    logic [3:0]         an_r;
    logic               dp_r;

    // Combinational helpers
    logic               scan_wrap_s;
    logic               frame_wrap_s;
    logic               blink_wrap_s;
    logic               capture_s;
    logic [2:0]         view_m10_s;
    logic [3:0]         view_m1_s;
    logic [2:0]         view_s10_s;
    logic [3:0]         view_s1_s;
    logic [3:0]         digit_s;
    logic               field_blank_s;
    logic               lead_blank_s;
    logic               blank_s;
    logic [6:0]         seg_nxt_s;
    logic [3:0]         an_nxt_s;
    logic               dp_nxt_s;

    // Counter wrap points and the shadow capture strobe.
    always_comb begin
        scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
        frame_wrap_s = scan_wrap_s && (idx_r == IDX_M10);
        blink_wrap_s = (blink_cnt_r == BLINK_LAST);
        capture_s    = first_r || frame_wrap_s;
    end

    // Digits shown this cycle: on the first cycle out of reset the shadow
    // still holds zeros, so the live bus is shown while it is being captured.
    always_comb begin
        if (first_r) begin
            view_m10_s = m10;
            view_m1_s  = m1;
            view_s10_s = s10;
            view_s1_s  = s1;
        end else begin
            view_m10_s = shd_m10_r;
            view_m1_s  = shd_m1_r;
            view_s10_s = shd_s10_r;
            view_s1_s  = shd_s1_r;
        end
    end

    // Select the digit for the active slot; 3-bit tens digits are zero-extended.
    always_comb begin
        case (idx_r)
            IDX_S1:  digit_s = view_s1_s;
            IDX_S10: digit_s = {1'b0, view_s10_s};
            IDX_M1:  digit_s = view_m1_s;
            IDX_M10: digit_s = {1'b0, view_m10_s};
            default: digit_s = 4'd0;
        endcase
    end

    // Blink blanking of the field under adjustment (sel=1 seconds, sel=0 minutes).
    always_comb begin
        field_blank_s = 1'b0;
        if (adj && blink_ph_r) begin
            if (sel) begin
                field_blank_s = (idx_r == IDX_S1) || (idx_r == IDX_S10);
            end else begin
                field_blank_s = (idx_r == IDX_M1) || (idx_r == IDX_M10);
            end
        end else begin
            field_blank_s = 1'b0;
        end
    end

    // Leading-zero suppression of the minutes-tens slot.
    always_comb begin
        lead_blank_s = 1'b0;
`ifdef LEAD_BLANK_EN
        if ((idx_r == IDX_M10) && (view_m10_s == 3'd0)) begin
            lead_blank_s = 1'b1;
        end else begin
            lead_blank_s = 1'b0;
        end
`else
        lead_blank_s = 1'b0;
`endif
    end

    // Next display pin values; a blanked slot darkens anode, segments and dp.
    always_comb begin
        blank_s   = field_blank_s || lead_blank_s;
        seg_nxt_s = SEG_OFF;
        an_nxt_s  = AN_OFF;
        dp_nxt_s  = 1'b1;
        if (blank_s) begin
            seg_nxt_s = SEG_OFF;
            an_nxt_s  = AN_OFF;
            dp_nxt_s  = 1'b1;
        end else begin
            seg_nxt_s = bcd_to_seg(digit_s);
            an_nxt_s  = anode_for(idx_r);
            dp_nxt_s  = (idx_r == IDX_M1) ? 1'b0 : 1'b1;
        end
    end

    // Scan timing: each slot stays lit for SCAN_DIV cycles, then idx advances.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            scan_cnt_r <= SCAN_ZERO;
            idx_r      <= IDX_S1;
        end else if (scan_wrap_s) begin
            scan_cnt_r <= SCAN_ZERO;
            idx_r      <= idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            idx_r      <= idx_r;
        end
    end

    // Marks the first cycle after reset so the shadow is loaded straight away.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            first_r <= 1'b1;
        end else begin
            first_r <= 1'b0;
        end
    end

    // Shadow digits: captured once per frame so mid-frame changes never tear.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            shd_m10_r <= 3'd0;
            shd_m1_r  <= 4'd0;
            shd_s10_r <= 3'd0;
            shd_s1_r  <= 4'd0;
        end else if (capture_s) begin
            shd_m10_r <= m10;
            shd_m1_r  <= m1;
            shd_s10_r <= s10;
            shd_s1_r  <= s1;
        end else begin
            shd_m10_r <= shd_m10_r;
            shd_m1_r  <= shd_m1_r;
            shd_s10_r <= shd_s10_r;
            shd_s1_r  <= shd_s1_r;
        end
    end

    // Blink phase generator; held cleared whenever adjust mode is off.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            blink_cnt_r <= BLINK_ZERO;
            blink_ph_r  <= 1'b0;
        end else if (!adj) begin
            blink_cnt_r <= BLINK_ZERO;
            blink_ph_r  <= 1'b0;
        end else if (blink_wrap_s) begin
            blink_cnt_r <= BLINK_ZERO;
            blink_ph_r  <= ~blink_ph_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            blink_ph_r  <= blink_ph_r;
        end
    end

    // Registered display pins; everything dark while in reset.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= seg_nxt_s;
            an_r  <= an_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg_display_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_display_mux
// Scoreboard bench: the driver applies inputs on the falling edge and pushes
// the expected pin values for the coming rising edge; a monitor pops and
// compares just after each rising edge. The reference model works from the
// elapsed cycle count since reset (slot = (n / SCAN_DIV) mod 4, frame capture
// at frame boundaries, blink phase from the length of the current adj run).
// -----------------------------------------------------------------------------
module tb_seg_display_mux;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic       clkAdj = 1'b0;
    logic       rst;
    logic       adj;
    logic       sel;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    seg_display_mux #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clkAdj (clkAdj),
        .rst    (rst),
        .adj    (adj),
        .sel    (sel),
        .m10    (m10),
        .m1     (m1),
        .s10    (s10),
        .s1     (s1),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    always #5 clkAdj = ~clkAdj;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    disp_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Next digit values the driver will present
    logic [2:0] nd_m10;
    logic [3:0] nd_m1;
    logic [2:0] nd_s10;
    logic [3:0] nd_s1;

    // Reference model state
    int         n_next  = 0;
    int         adj_run = 0;
    int         frame_dig [4];
    logic [6:0] seg_tab [16];

    // Capture the digits currently on the bus as the model's frame contents.
    task automatic model_capture();
        frame_dig[0] = int'(s1);
        frame_dig[1] = int'(s10);
        frame_dig[2] = int'(m1);
        frame_dig[3] = int'(m10);
    endtask

    // Expected pins for the rising edge that follows the current inputs.
    task automatic model_edge(output disp_t e);
        int         n;
        int         pos;
        int         idx;
        int         ph;
        logic       blank;
        logic [3:0] one_hot;
        if (rst) begin
            e       = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
            n_next  = 0;
            adj_run = 0;
        end else begin
            n   = n_next;
            pos = n % FRAME;
            if (n == 0) model_capture();
            idx   = pos / SCAN_DIV;
            ph    = (adj_run / BLINK_DIV) % 2;
            blank = adj && (ph == 1) && (sel ? (idx < 2) : (idx >= 2));
`ifdef LEAD_BLANK_EN
            if (idx == 3 && frame_dig[3] == 0) blank = 1'b1;
`endif
            if (blank) begin
                e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
            end else begin
                one_hot = 4'b0001 << idx;
                e.an    = ~one_hot;
                e.seg   = seg_tab[frame_dig[idx]];
                e.dp    = (idx == 2) ? 1'b0 : 1'b1;
            end
            if (pos == FRAME - 1) model_capture();
            adj_run = adj ? adj_run + 1 : 0;
            n_next  = n + 1;
        end
    endtask

    // Drive one cycle of stimulus and queue its expected response.
    task automatic step(input logic r, input logic a, input logic s);
        disp_t e;
        @(negedge clkAdj);
        rst = r;
        adj = a;
        sel = s;
        m10 = nd_m10;
        m1  = nd_m1;
        s10 = nd_s10;
        s1  = nd_s1;
        model_edge(e);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every registered output against the scoreboard.
    initial begin
        disp_t e;
        forever begin
            @(posedge clkAdj);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL display t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                             $time, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic ra;
        logic rs;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        for (int i = 0; i < 4; i++) frame_dig[i] = 0;
        rst = 1'b1; adj = 1'b0; sel = 1'b0;
        m10 = 3'd0; m1 = 4'd0; s10 = 3'd0; s1 = 4'd0;
        nd_m10 = 3'd1; nd_m1 = 4'd2; nd_s10 = 3'd3; nd_s1 = 4'd4;

        // Reset, release, and scan through the first slots
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        // s1 changes while idx=2: visible only from the next frame
        nd_s1 = 4'd5;
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0);
        // Out-of-range digit shows a dash
        nd_s1 = 4'd12;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        nd_s1 = 4'd4;
        // Blink seconds, then drop adj
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        // Blink minutes, then flip sel mid-phase
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, ((i / 3) % 2) == 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        // Reset landing at idx=2, scan_cnt=1
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * SCAN_DIV + 1; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        nd_m10 = 3'd0;
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 1'b0);

        // Randomized traffic
        ra = 1'b0;
        rs = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                nd_m10 = 3'($urandom_range(0, 7));
                nd_m1  = 4'($urandom_range(0, 15));
                nd_s10 = 3'($urandom_range(0, 7));
                nd_s1  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) == 0) ra = ~ra;
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            step(($urandom_range(0, 149) == 0), ra, rs);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clkAdj);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
